shift_add_multiply_gen: RTL

- Parametrised sequential shift-and-add multiplier; successor to the fixed 16-bit unsigned shift-add multiplier.
- Adds generic operand width, a per-operation signed/unsigned mode, synchronous reset, a one-cycle done pulse and explicit back-to-back start acceptance.
- Sits as a multi-cycle arithmetic unit under a controller that issues start and waits for ready or done.

---
 rtl/shift_add_multiply_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/shift_add_multiply_gen.sv
// rtl/shift_add_multiply_gen.sv - parametrised sequential shift-and-add multiplier, signed/unsigned
module shift_add_multiply_gen #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     product_q, product_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  mag_a, mag_b;

    // Magnitudes in WIDTH bits; the most negative value maps onto itself as an unsigned 2^(W-1).
    assign mag_a = (signed_mode && multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;
    assign mag_b = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(1)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mag_b};
                    mplier_d = mag_a;
                    neg_d    = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                    cnt_d    = CW'(WIDTH);
                end
            end
            S_RUN: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
            end
            S_FIN: begin
                product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        ready   = (state_q == S_IDLE);
        done    = done_q;
        product = product_q;
    end

endmodule
